occupancy_grid_updater: RTL and testbench

- Parametrised occupancy-grid map store and hit-update engine for the Hector SLAM FPGA datapath.
- After reset it clears the map in hardware. On each `start` pulse it accepts a batch of scan-endpoint cell coordinates and saturating-increments each addressed cell.
- A read port lets the scan matcher sample cell values at any time.
- Successor to the fixed-size map logic in `hector_slam_fpga`: generalised in map size, cell width and increment, with full-throughput read-modify-write and hazard forwarding.

---
 rtl/occupancy_grid_updater.sv | 182 ++++++++++++++++++
 tb/tb_occupancy_grid_updater.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/occupancy_grid_updater.sv
// Occupancy-grid map store: hardware clear after reset, then pipelined saturating hit updates.
// Define OCCUPANCY_GRID_HIT_COUNT_EN to add the 16-bit hit_count output.
module occupancy_grid_updater #(
  parameter int unsigned MAP_DIM_LOG2 = 7,
  parameter int unsigned CELL_WIDTH   = 8,
  parameter int unsigned CELL_INIT    = 128,
  parameter int unsigned HIT_INC      = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    init_done,
  input  logic                    point_valid,
  output logic                    point_ready,
  input  logic [MAP_DIM_LOG2-1:0] point_x,
  input  logic [MAP_DIM_LOG2-1:0] point_y,
  input  logic                    point_last,
  input  logic [MAP_DIM_LOG2-1:0] rd_x,
  input  logic [MAP_DIM_LOG2-1:0] rd_y,
  output logic [CELL_WIDTH-1:0]   rd_data
`ifdef OCCUPANCY_GRID_HIT_COUNT_EN
  ,
  output logic [15:0]             hit_count
`endif
);

  localparam int unsigned AW = 2 * MAP_DIM_LOG2;
  localparam int unsigned N  = 1 << AW;

  localparam logic [CELL_WIDTH-1:0] CELL_MAX  = '1;
  localparam logic [CELL_WIDTH-1:0] INIT_VAL  = CELL_WIDTH'(CELL_INIT);
  localparam logic [CELL_WIDTH:0]   INC_VAL   = (CELL_WIDTH + 1)'(HIT_INC);

  localparam logic [2:0] ST_CLEAR = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_FLUSH = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [CELL_WIDTH-1:0] mem_q [N];

  logic [2:0]            state_q, state_d;
  logic [AW-1:0]         clr_cnt_q, clr_cnt_d;
  logic                  init_done_q, init_done_d;

  logic                  s0_valid_q, s0_valid_d;
  logic [AW-1:0]         s0_addr_q, s0_addr_d;
  logic                  s1_valid_q, s1_valid_d;
  logic [AW-1:0]         s1_addr_q, s1_addr_d;
  logic [CELL_WIDTH-1:0] s1_old_q, s1_old_d;
  logic [CELL_WIDTH:0]   s1_sum;
  logic [CELL_WIDTH-1:0] s1_new;
  logic                  fwd;

  logic [CELL_WIDTH-1:0] rd_data_q;

  logic                  accept;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [CELL_WIDTH-1:0] wr_data;

  assign accept = (state_q == ST_RUN) && point_valid;

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    init_done_d = init_done_q;
    case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + AW'(1);
        if (&clr_cnt_q) begin
          state_d     = ST_IDLE;
          init_done_d = 1'b1;
        end
      end
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (accept && point_last) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        // Once stage 0 is empty the final write is on this edge, so DONE follows it.
        if (!s0_valid_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // Stage 1 result, saturating at the all-ones cell value.
  always_comb begin
    s1_sum = {1'b0, s1_old_q} + INC_VAL;
    s1_new = (s1_sum > {1'b0, CELL_MAX}) ? CELL_MAX : s1_sum[CELL_WIDTH-1:0];
  end

  // A same-cell point right behind stage 1 would read the pre-write value, so take stage 1's result.
  always_comb begin
    s0_valid_d = accept;
    s0_addr_d  = {point_y, point_x};
    s1_valid_d = s0_valid_q;
    s1_addr_d  = s0_addr_q;
    fwd        = s1_valid_q && (s1_addr_q == s0_addr_q);
    s1_old_d   = fwd ? s1_new : mem_q[s0_addr_q];
  end

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = s1_addr_q;
    wr_data = s1_new;
    if (!reset) begin
      if (state_q == ST_CLEAR) begin
        wr_en   = 1'b1;
        wr_addr = clr_cnt_q;
        wr_data = INIT_VAL;
      end else if (s1_valid_q) begin
        wr_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_CLEAR;
      clr_cnt_q   <= '0;
      init_done_q <= 1'b0;
      s0_valid_q  <= 1'b0;
      s0_addr_q   <= '0;
      s1_valid_q  <= 1'b0;
      s1_addr_q   <= '0;
      s1_old_q    <= '0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      init_done_q <= init_done_d;
      s0_valid_q  <= s0_valid_d;
      s0_addr_q   <= s0_addr_d;
      s1_valid_q  <= s1_valid_d;
      s1_addr_q   <= s1_addr_d;
      s1_old_q    <= s1_old_d;
      rd_data_q   <= mem_q[{rd_y, rd_x}];
    end
  end

`ifdef OCCUPANCY_GRID_HIT_COUNT_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;

  always_comb begin
    hit_cnt_d = hit_cnt_q;
    if ((state_q == ST_IDLE) && start) begin
      hit_cnt_d = '0;
    end else if (accept && (hit_cnt_q != 16'hFFFF)) begin
      hit_cnt_d = hit_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) hit_cnt_q <= '0;
    else       hit_cnt_q <= hit_cnt_d;
  end

  assign hit_count = hit_cnt_q;
`endif

  assign busy        = (state_q == ST_CLEAR) || (state_q == ST_RUN) || (state_q == ST_FLUSH);
  assign done        = (state_q == ST_DONE);
  assign point_ready = (state_q == ST_RUN);
  assign init_done   = init_done_q;
  assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_occupancy_grid_updater.sv
// Self-checking bench for occupancy_grid_updater: cycle-level behavioural model plus directed literal checks.
module tb_occupancy_grid_updater;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       point_valid = 1'b0;
  logic       point_last = 1'b0;
  logic [3:0] point_x = '0;
  logic [3:0] point_y = '0;
  logic [3:0] rd_x = '0;
  logic [3:0] rd_y = '0;
  logic       busy, done, init_done, point_ready;
  logic [7:0] rd_data;
`ifdef OCCUPANCY_GRID_HIT_COUNT_EN
  logic [15:0] hit_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  occupancy_grid_updater #(
    .MAP_DIM_LOG2(4),
    .CELL_WIDTH  (8),
    .CELL_INIT   (128),
    .HIT_INC     (16)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .init_done  (init_done),
    .point_valid(point_valid),
    .point_ready(point_ready),
    .point_x    (point_x),
    .point_y    (point_y),
    .point_last (point_last),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .rd_data    (rd_data)
`ifdef OCCUPANCY_GRID_HIT_COUNT_EN
    ,
    .hit_count  (hit_count)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Behavioural model: map contents, pending hits with the cycle they commit, batch timing.
  int mmap [256];
  int pend_addr [$];
  int pend_land [$];
  int cyc = 0;
  int clr_start = 0;
  bit armed = 0;
  bit rst_prev = 0;
  bit batch = 0;
  int last_acc = -100;
  int exp_rd = 0;
  bit rd_ok = 0;
  int mhit = 0;
  bit exp_init, exp_busy, exp_done, idle;

  always @(negedge clock) begin
    if (rst_prev) clr_start = cyc;
    exp_init = armed && !rst_prev && (cyc >= clr_start + 256);
    exp_busy = !exp_init || batch || (cyc == last_acc + 1) || (cyc == last_acc + 2);
    exp_done = (cyc == last_acc + 3);
    idle     = exp_init && !exp_busy && !exp_done;

    if (armed) begin
      if (rst_prev) begin
        chk("reset_busy", busy, 1);
        chk("reset_done", done, 0);
        chk("reset_init_done", init_done, 0);
        chk("reset_point_ready", point_ready, 0);
        chk("reset_rd_data", rd_data, 0);
`ifdef OCCUPANCY_GRID_HIT_COUNT_EN
        chk("reset_hit_count", hit_count, 0);
`endif
      end else begin
        chk("busy", busy, exp_busy);
        chk("done", done, exp_done);
        chk("init_done", init_done, exp_init);
        chk("point_ready", point_ready, batch);
        if (rd_ok) chk("rd_data", rd_data, exp_rd);
`ifdef OCCUPANCY_GRID_HIT_COUNT_EN
        chk("hit_count", hit_count, mhit);
`endif
      end
    end

    rd_ok  = armed && !reset && exp_init;
    exp_rd = mmap[{rd_y, rd_x}];
    while (pend_land.size() > 0 && pend_land[0] == cyc) begin
      mmap[pend_addr[0]] = (mmap[pend_addr[0]] + 16 > 255) ? 255 : mmap[pend_addr[0]] + 16;
      void'(pend_addr.pop_front());
      void'(pend_land.pop_front());
    end
    if (batch && point_valid) begin
      pend_addr.push_back({point_y, point_x});
      pend_land.push_back(cyc + 2);
      if (mhit < 65535) mhit++;
      if (point_last) begin
        batch = 0;
        last_acc = cyc;
      end
    end else if (idle && start) begin
      batch = 1;
      mhit = 0;
    end
    if (reset) begin
      armed = 1;
      batch = 0;
      last_acc = -100;
      mhit = 0;
      pend_addr.delete();
      pend_land.delete();
      for (int i = 0; i < 256; i++) mmap[i] = 128;
    end
    rst_prev = reset;
    cyc++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic push_point(input int x, input int y, input bit last);
    point_x = 4'(x);
    point_y = 4'(y);
    point_last = last;
    point_valid = 1'b1;
    tick();
    point_valid = 1'b0;
    point_last = 1'b0;
  endtask

  // Called right after the last point's cycle; returns ticks from that cycle to done.
  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 50) begin
      tick();
      n++;
    end
    if (!done) chk("done_timeout", 0, 1);
    tick();
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (!init_done && n < 400) begin
      tick();
      n++;
    end
  endtask

  task automatic read_cell(input int addr, output int val);
    rd_x = addr[3:0];
    rd_y = addr[7:4];
    @(posedge clock);
    @(negedge clock);
    val = rd_data;
    @(posedge clock);
    #1;
  endtask

  task automatic sweep();
    for (int i = 0; i < 256; i++) begin
      rd_x = i[3:0];
      rd_y = i[7:4];
      tick();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n;
    int v;
    int len;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    wait_init(n);
    chk("init_latency", n, 256);
    chk("busy_after_init", busy, 0);
    sweep();
    read_cell(8'hA5, v);
    chk("clear_cell_a5", v, 128);

    do_start();
    push_point(3, 5, 1'b1);
    wait_done(n);
    chk("done_latency", n, 3);
    chk("done_one_cycle", done, 0);
    read_cell(8'h53, v);
    chk("single_cell_53", v, 144);
    read_cell(8'h35, v);
    chk("single_cell_35", v, 128);
    sweep();

    do_start();
    repeat (7) push_point(7, 7, 1'b0);
    repeat (4) tick();
    read_cell(8'h77, v);
    chk("sat_after_7", v, 240);
    push_point(7, 7, 1'b0);
    push_point(7, 7, 1'b0);
    push_point(7, 7, 1'b1);
    wait_done(n);
    read_cell(8'h77, v);
    chk("sat_after_10", v, 255);

    do_start();
    for (int i = 0; i < 10; i++) push_point(9, 9, i == 9);
    wait_done(n);
    read_cell(8'h99, v);
    chk("b2b_10_cell_99", v, 255);

    do_start();
    for (int i = 0; i < 4; i++) begin
      chk("alt_ready", point_ready, 1);
      push_point((i % 2) + 1, (i % 2) + 1, i == 3);
    end
    wait_done(n);
    read_cell(8'h11, v);
    chk("alt_cell_11", v, 160);
    read_cell(8'h22, v);
    chk("alt_cell_22", v, 160);

    for (int b = 0; b < 6; b++) begin
      do_start();
      len = $urandom_range(1, 20);
      for (int j = 0; j < len; j++) begin
        while ($urandom_range(0, 2) == 0) begin
          start = $urandom_range(0, 1);
          rd_x = 4'($urandom_range(0, 3));
          rd_y = 4'($urandom_range(0, 3));
          tick();
          start = 1'b0;
        end
        rd_x = 4'($urandom_range(0, 3));
        rd_y = 4'($urandom_range(0, 3));
        push_point($urandom_range(0, 3), $urandom_range(0, 3), j == len - 1);
      end
      start = $urandom_range(0, 1);
      wait_done(n);
      start = 1'b0;
      for (int k = 0; k < 8; k++) begin
        rd_x = 4'($urandom_range(0, 3));
        rd_y = 4'($urandom_range(0, 3));
        tick();
      end
    end

    do_start();
    push_point(4, 4, 1'b0);
    push_point(4, 4, 1'b0);
    point_x = 4'd4;
    point_y = 4'd4;
    point_valid = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    point_valid = 1'b0;
    chk("midrun_reset_busy", busy, 1);
    chk("midrun_reset_init_done", init_done, 0);
    wait_init(n);
    chk("reclear_latency", n, 256);
    sweep();
    read_cell(8'h44, v);
    chk("reclear_cell_44", v, 128);

`ifdef OCCUPANCY_GRID_HIT_COUNT_EN
    do_start();
    for (int i = 0; i < 6; i++) begin
      push_point(i, 2, i == 5);
      if (i < 5) repeat (2) tick();
    end
    wait_done(n);
    chk("hit_count_after_batch", hit_count, 6);
    do_start();
    chk("hit_count_after_start", hit_count, 0);
    push_point(0, 0, 1'b1);
    wait_done(n);
`endif

    repeat (4) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
